hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
// - Drives the active-high hold inputs (EN, 1 = hold, 0 = capture) of the pipeline stage registers.
// - Drives the bubble select that zeroes the ID/EX register inputs.
// - Detects load-use hazards between the ID and EX stages.
// - Freezes the whole pipeline while a MEM-stage read waits for data memory.
// - Reports stall statistics and a memory-timeout error.
// PARAMETERS
// - REG_W       4   register index width
// - NULL_REG    15  register index meaning "no operand"; never creates a hazard
// - MEM_TIMEOUT 64  max wait cycles for mem_ack before forced release (>= 2)
// - CNT_W       16  width of stall_cnt
// PORTS
// - clk            in   1      single clock; all state updates on its rising edge
// - rst_n          in   1      reset: asynchronous, active-low
// - id_rs_a        in   REG_W  ID-stage source operand A
// - id_rs_b        in   REG_W  ID-stage source operand B
// - id_rs_c        in   REG_W  ID-stage source operand C
// - ex_mem_RE      in   1      instruction in EX is a load (mem_RE leaving ID/EX)
// - ex_rd          in   REG_W  destination register of the EX instruction
// - mem_RE         in   1      instruction in MEM issues a data-memory read this cycle
// - mem_ack        in   1      data memory returns read data this cycle
// - hold_ifid      out  1      EN of the IF/ID register and PC (1 = hold)
// - hold_idex      out  1      EN of the ID/EX register
// - hold_exmem     out  1      EN of the EX/MEM register
// - hold_memwb     out  1      EN of the MEM/WB register
// - bubble_idex    out  1      force ID/EX inputs to NOP: mem_RE = 0, all reg fields = NULL_REG
// - mem_timeout    out  1      one-cycle pulse on forced release
// - stall_cnt      out  CNT_W  saturating count of cycles with hold_ifid = 1
// BEHAVIOUR
// Reset
// - All state is cleared asynchronously.
// - While rst_n = 0:
//   - state = RUN and the wait counter = 0.
//   - stall_cnt = 0 and mem_timeout = 0.
//   - All hold_* = 0 and bubble_idex = 1, so NOPs flush the un-reset stage registers.
// Hazard terms
// - luse = ex_mem_RE & (ex_rd != NULL_REG) & (ex_rd matches id_rs_a, id_rs_b or id_rs_c).
//   - A source operand equal to NULL_REG never matches.
// - mwait = mem_RE & ~mem_ack.
// Outputs
// - Outputs are combinational from the current state and inputs.
// - They must act at the same clock edge, so the stage registers see them in the hazard cycle.
// State machine: RUN, MEM_WAIT
// - RUN, mwait = 1:
//   - All four hold_* = 1 and bubble_idex = 0.
//   - Next state MEM_WAIT; wait counter loads 1.
// - RUN, luse = 1 and mwait = 0:
//   - hold_ifid = hold_idex = 1 and bubble_idex = 1.
//   - hold_exmem = hold_memwb = 0, so the load advances.
//   - Exactly one bubble is inserted; the next cycle re-evaluates with the load in MEM.
// - RUN, otherwise:
//   - All hold_* = 0 and bubble_idex = 0.
// - MEM_WAIT:
//   - All hold_* = 1; the wait counter increments.
//   - mwait has priority over luse. Memory wait freezes everything, so no bubble is inserted.
//   - luse is re-evaluated once the pipeline moves again.
// - MEM_WAIT, mem_ack = 1:
//   - All hold_* = 0 this cycle; the data is captured into MEM/WB.
//   - Next state RUN.
// - MEM_WAIT, counter reaches MEM_TIMEOUT with mem_ack = 0:
//   - Forced release: all hold_* = 0 and mem_timeout = 1 for that cycle.
//   - Next state RUN; the counter clears.
// - MEM_WAIT, mem_RE drops (upstream cancel):
//   - Release as for mem_ack; no timeout pulse.
// Statistics and reset timing
// - stall_cnt increments on every clock with hold_ifid = 1 and saturates at all-ones; it does not wrap.
// - Reset asserted mid-stall: the state returns to RUN immediately; the pending wait is discarded.
// - Reset is released synchronously by the surrounding reset synchroniser; no special first-cycle handling.
// STRUCTURE
// - Package proc_pkg:
//   - REG_W and NULL_REG constants.
//   - Typedef stall_state_t {RUN, MEM_WAIT}.
// - Sub-module stall_timer:
//   - Loadable up-counter with terminal-count flag (width $clog2(MEM_TIMEOUT+1)).
//   - Cleared by rst_n.
// - Hazard compare, FSM and saturating stall_cnt stay in the top module.
// TESTING
// - Reset: rst_n = 0 mid-run -> all hold_* = 0, bubble_idex = 1, stall_cnt = 0, state RUN.
// - Load-use: ex_mem_RE = 1, ex_rd = 3, id_rs_b = 3
//   -> exactly 1 cycle of hold_ifid = hold_idex = bubble_idex = 1 with hold_exmem = 0; stall_cnt = 1.
// - Null operand: ex_rd = 15, id_rs_a = 15, ex_mem_RE = 1 -> no stall, all outputs 0.
// - Memory wait: mem_RE = 1, mem_ack = 0 for 5 cycles then 1
//   -> hold_* = 1 for 5 cycles, released on the ack cycle; stall_cnt = 5.
// - Priority: luse and mwait together -> full freeze, bubble_idex = 0.
//   - After the ack, the load-use bubble follows only if the dependency still holds.
// - Timeout: MEM_TIMEOUT = 4, mem_ack never asserted -> release after 4 wait cycles,
//   single mem_timeout pulse, state RUN.
// - Saturation: CNT_W = 3, hold for 10 cycles -> stall_cnt sticks at 7.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared pipeline-control definitions: register index format and the
// stall controller state encoding.
package proc_pkg;

  // Register index width and the index that stands for "no operand".
  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t NULL_REG = reg_idx_t'(15);

  // Stall controller states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stall_state_t;

  // True when a real destination register feeds the given source operand.
  // A NULL_REG destination never matches, so an absent source (also
  // NULL_REG) can never create a hazard.
  function automatic logic src_hits(input reg_idx_t rd, input reg_idx_t rs);
    return (rd != NULL_REG) && (rd == rs);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Loadable up-counter that measures how long the pipeline has been frozen
// waiting for data memory. tc_o flags that the count has reached MAX_COUNT.
module stall_timer #(
  parameter int MAX_COUNT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int TW = $clog2(MAX_COUNT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Terminal count: the wait has lasted MAX_COUNT cycles.
  assign tc_o = (count_q == TW'(MAX_COUNT));

  // Next count: clear wins over load, load wins over increment; the count
  // never moves past MAX_COUNT.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = TW'(1);
    end else if (inc_i && !tc_o) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller. Generates the hold (EN) inputs of
// the four stage registers and the ID/EX bubble select, inserting a single
// bubble on a load-use hazard and freezing the whole pipeline while a
// MEM-stage read waits for data memory. Counts stalled cycles and flags a
// forced release when memory never answers.
module hazard_stall_ctrl
  import proc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic [REG_W-1:0] id_rs_c,
  input  logic             ex_mem_RE,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_RE,
  input  logic             mem_ack,
  output logic             hold_ifid,
  output logic             hold_idex,
  output logic             hold_exmem,
  output logic             hold_memwb,
  output logic             bubble_idex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  stall_state_t     state_q;
  stall_state_t     state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic luse;
  logic mwait;
  logic tmr_clr;
  logic tmr_load;
  logic tmr_inc;
  logic tmr_tc;

  // Hazard terms: load in EX feeding any ID operand, and an unanswered read in MEM.
  assign luse  = ex_mem_RE &&
                 (src_hits(ex_rd, id_rs_a) ||
                  src_hits(ex_rd, id_rs_b) ||
                  src_hits(ex_rd, id_rs_c));
  assign mwait = mem_RE && !mem_ack;

  stall_timer #(
    .MAX_COUNT (MEM_TIMEOUT)
  ) u_stall_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .load_i (tmr_load),
    .inc_i  (tmr_inc),
    .tc_o   (tmr_tc)
  );

  // Next state and combinational stage controls; memory wait outranks load-use.
  always_comb begin
    state_d     = state_q;
    hold_ifid   = 1'b0;
    hold_idex   = 1'b0;
    hold_exmem  = 1'b0;
    hold_memwb  = 1'b0;
    bubble_idex = 1'b0;
    mem_timeout = 1'b0;
    tmr_clr     = 1'b0;
    tmr_load    = 1'b0;
    tmr_inc     = 1'b0;

    case (state_q)
      RUN: begin
        if (mwait) begin
          // Full freeze; the bubble is not needed since nothing moves.
          hold_ifid  = 1'b1;
          hold_idex  = 1'b1;
          hold_exmem = 1'b1;
          hold_memwb = 1'b1;
          tmr_load   = 1'b1;
          state_d    = MEM_WAIT;
        end else if (luse) begin
          // Keep the consumer in ID, let the load move on to MEM.
          hold_ifid   = 1'b1;
          hold_idex   = 1'b1;
          bubble_idex = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (!mwait) begin
          // Data arrived or the read was cancelled: everything moves this cycle.
          tmr_clr = 1'b1;
          state_d = RUN;
        end else if (tmr_tc) begin
          // Memory never answered: release anyway and report it.
          mem_timeout = 1'b1;
          tmr_clr     = 1'b1;
          state_d     = RUN;
        end else begin
          hold_ifid  = 1'b1;
          hold_idex  = 1'b1;
          hold_exmem = 1'b1;
          hold_memwb = 1'b1;
          tmr_inc    = 1'b1;
        end
      end

      default: begin
        tmr_clr = 1'b1;
        state_d = RUN;
      end
    endcase

    // NOTE: outputs are gated by rst_n directly because the stage registers are
    // not reset; while reset is held they must capture NOPs every cycle.
    if (!rst_n) begin
      hold_ifid   = 1'b0;
      hold_idex   = 1'b0;
      hold_exmem  = 1'b0;
      hold_memwb  = 1'b0;
      bubble_idex = 1'b1;
      mem_timeout = 1'b0;
    end
  end

  // Saturating count of cycles in which the front end is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_ifid && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and statistics registers; a reset mid-stall drops the pending wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. Two instances share one stimulus stream:
// dut_a with default parameters, dut_b with a short memory timeout and a
// narrow stall counter. Each is compared every cycle against a reference
// model; a vector table carries explicit expectations for dut_a.
module tb_hazard_stall_ctrl;

  localparam int TO_A   = 64;
  localparam int CW_A   = 16;
  localparam int TO_B   = 4;
  localparam int CW_B   = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_rs_a, id_rs_b, id_rs_c;
  logic       ex_mem_RE;
  logic [3:0] ex_rd;
  logic       mem_RE, mem_ack;

  logic            a_ifid, a_idex, a_exmem, a_memwb, a_bub, a_to;
  logic [CW_A-1:0] a_cnt;
  logic            b_ifid, b_idex, b_exmem, b_memwb, b_bub, b_to;
  logic [CW_B-1:0] b_cnt;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_c(id_rs_c),
    .ex_mem_RE(ex_mem_RE), .ex_rd(ex_rd), .mem_RE(mem_RE), .mem_ack(mem_ack),
    .hold_ifid(a_ifid), .hold_idex(a_idex), .hold_exmem(a_exmem), .hold_memwb(a_memwb),
    .bubble_idex(a_bub), .mem_timeout(a_to), .stall_cnt(a_cnt)
  );

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_c(id_rs_c),
    .ex_mem_RE(ex_mem_RE), .ex_rd(ex_rd), .mem_RE(mem_RE), .mem_ack(mem_ack),
    .hold_ifid(b_ifid), .hold_idex(b_idex), .hold_exmem(b_exmem), .hold_memwb(b_memwb),
    .bubble_idex(b_bub), .mem_timeout(b_to), .stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic [3:0] a, b, c;
    logic       ex_re;
    logic [3:0] ex_rd;
    logic       mre, mack;
    logic [3:0] e_hold;   // {ifid, idex, exmem, memwb}
    logic       e_bub;
    logic       e_to;
    int         e_cnt;    // dut_a stall_cnt seen during this cycle
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: waiting flag, cycles frozen so far,
  // and the statistic as an unbounded integer clipped at the counter maximum.
  bit m_wait  [2];
  int m_waited[2];
  int m_stall [2];
  int m_tmo   [2];
  int m_cmax  [2];

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rn, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic ex_re, input logic [3:0] rd,
                              input logic mre, input logic mack, input logic [3:0] eh,
                              input logic eb, input logic et, input int ec);
    vec_t v;
    v.rn = rn; v.a = a; v.b = b; v.c = c; v.ex_re = ex_re; v.ex_rd = rd;
    v.mre = mre; v.mack = mack; v.e_hold = eh; v.e_bub = eb; v.e_to = et; v.e_cnt = ec;
    return v;
  endfunction

  // Model: what the controller must do this cycle, then its new state.
  task automatic model_step(input int d, input vec_t v, output logic [3:0] hold,
                            output logic bub, output logic to, output int cnt);
    bit luse, mwait, frz;
    luse  = v.ex_re && (v.ex_rd != 4'd15) &&
            (v.ex_rd == v.a || v.ex_rd == v.b || v.ex_rd == v.c);
    mwait = v.mre && !v.mack;
    hold = 4'b0000; bub = 1'b0; to = 1'b0; frz = 1'b0;
    if (!v.rn) begin
      m_wait[d] = 1'b0; m_waited[d] = 0; m_stall[d] = 0;
      bub = 1'b1;
      cnt = 0;
      return;
    end
    cnt = m_stall[d];
    if (!m_wait[d]) begin
      if (mwait)     begin frz = 1'b1; m_wait[d] = 1'b1; m_waited[d] = 1; end
      else if (luse) begin hold = 4'b1100; bub = 1'b1; end
    end else begin
      if (!mwait)                          begin m_wait[d] = 1'b0; m_waited[d] = 0; end
      else if (m_waited[d] == m_tmo[d])    begin m_wait[d] = 1'b0; m_waited[d] = 0; to = 1'b1; end
      else                                 begin frz = 1'b1; m_waited[d]++; end
    end
    if (frz) hold = 4'b1111;
    if (hold[3] && m_stall[d] < m_cmax[d]) m_stall[d]++;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, compare
  // both instances against the model and optionally against the table row.
  task automatic apply(input vec_t v, input bit use_tbl, input string tag);
    logic [3:0] h; logic bb, tt; int cc;
    @(negedge clk);
    rst_n = v.rn; id_rs_a = v.a; id_rs_b = v.b; id_rs_c = v.c;
    ex_mem_RE = v.ex_re; ex_rd = v.ex_rd; mem_RE = v.mre; mem_ack = v.mack;
    #1;
    model_step(0, v, h, bb, tt, cc);
    check({tag, " a.hold"}, int'({a_ifid, a_idex, a_exmem, a_memwb}), int'(h));
    check({tag, " a.bubble"}, int'(a_bub), int'(bb));
    check({tag, " a.timeout"}, int'(a_to), int'(tt));
    check({tag, " a.stall_cnt"}, int'(a_cnt), cc);
    if (use_tbl) begin
      check({tag, " tbl.hold"}, int'({a_ifid, a_idex, a_exmem, a_memwb}), int'(v.e_hold));
      check({tag, " tbl.bubble"}, int'(a_bub), int'(v.e_bub));
      check({tag, " tbl.timeout"}, int'(a_to), int'(v.e_to));
      check({tag, " tbl.stall_cnt"}, int'(a_cnt), v.e_cnt);
    end
    model_step(1, v, h, bb, tt, cc);
    check({tag, " b.hold"}, int'({b_ifid, b_idex, b_exmem, b_memwb}), int'(h));
    check({tag, " b.bubble"}, int'(b_bub), int'(bb));
    check({tag, " b.timeout"}, int'(b_to), int'(tt));
    check({tag, " b.stall_cnt"}, int'(b_cnt), cc);
  endtask

  initial begin
    vec_t idle, memw, v;
    int   tocount;

    rst_n = 1'b0; id_rs_a = 4'd1; id_rs_b = 4'd2; id_rs_c = 4'd4;
    ex_mem_RE = 1'b0; ex_rd = 4'd0; mem_RE = 1'b0; mem_ack = 1'b0;
    m_tmo[0] = TO_A; m_cmax[0] = (1 << CW_A) - 1;
    m_tmo[1] = TO_B; m_cmax[1] = (1 << CW_B) - 1;
    for (int d = 0; d < 2; d++) begin m_wait[d] = 1'b0; m_waited[d] = 0; m_stall[d] = 0; end

    // ---------------- directed vector table (expectations for dut_a) ----------
    tbl.push_back(mk(0, 1, 3, 4, 1,  3, 1, 0, 4'b0000, 1, 0, 0));  // reset overrides hazards
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 0));  // idle
    tbl.push_back(mk(1, 1, 3, 4, 1,  3, 0, 0, 4'b1100, 1, 0, 0));  // load-use on operand B
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 1));  // single bubble only
    tbl.push_back(mk(1,15, 2, 4, 1, 15, 0, 0, 4'b0000, 0, 0, 1));  // NULL_REG never hazards
    for (int i = 0; i < 5; i++)                                     // memory wait, 5 cycles
      tbl.push_back(mk(1, 1, 2, 4, 0, 0, 1, 0, 4'b1111, 0, 0, 1 + i));
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 1, 1, 4'b0000, 0, 0, 6));  // ack releases
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 6));
    tbl.push_back(mk(1, 3, 2, 4, 1,  3, 1, 0, 4'b1111, 0, 0, 6));  // luse + mwait: freeze, no bubble
    tbl.push_back(mk(1, 3, 2, 4, 1,  3, 1, 1, 4'b0000, 0, 0, 7));  // ack cycle: release
    tbl.push_back(mk(1, 3, 2, 4, 1,  3, 0, 0, 4'b1100, 1, 0, 7));  // dependency persists: bubble
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 8));
    tbl.push_back(mk(1, 3, 2, 4, 1,  3, 1, 0, 4'b1111, 0, 0, 8));  // freeze again
    tbl.push_back(mk(1, 3, 2, 4, 1,  3, 1, 1, 4'b0000, 0, 0, 9));  // ack
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 9));  // dependency gone: no bubble
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 1, 0, 4'b1111, 0, 0, 9));  // wait
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 10)); // mem_RE drops: release, no pulse
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 10));
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 1, 0, 4'b1111, 0, 0, 10)); // wait
    tbl.push_back(mk(0, 1, 2, 4, 0,  0, 1, 0, 4'b0000, 1, 0, 0));  // reset mid-stall
    tbl.push_back(mk(1, 1, 2, 3, 1,  3, 0, 0, 4'b1100, 1, 0, 0));  // back in RUN: load-use acts
    tbl.push_back(mk(1, 1, 2, 4, 0,  0, 0, 0, 4'b0000, 0, 0, 1));

    foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // ---------------- timeout and saturation sequence --------------------------
    idle = mk(1, 1, 2, 4, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    memw = mk(1, 1, 2, 4, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    v = idle; v.rn = 1'b0;
    apply(v, 1'b0, "seq.rst");
    apply(idle, 1'b0, "seq.idle");
    tocount = 0;
    for (int k = 1; k <= 12; k++) begin
      apply(memw, 1'b0, $sformatf("seq.wait%0d", k));
      check($sformatf("seq.b_to_cycle%0d", k), int'(b_to), (k == 5 || k == 10) ? 1 : 0);
      check($sformatf("seq.b_hold_cycle%0d", k), int'(b_ifid), (k == 5 || k == 10) ? 0 : 1);
      if (b_to) tocount++;
    end
    check("seq.b_timeout_pulses", tocount, 2);
    apply(idle, 1'b0, "seq.after");
    check("seq.b_stall_saturated", int'(b_cnt), 7);
    check("seq.a_stall_12", int'(a_cnt), 12);
    apply(idle, 1'b0, "seq.after2");
    check("seq.b_stall_sticks", int'(b_cnt), 7);

    // ---------------- randomized stimulus against the model --------------------
    for (int n = 0; n < 3000; n++) begin
      v.rn    = ($urandom_range(0, 149) != 0);
      v.ex_rd = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      v.a     = ($urandom_range(0, 3) == 0) ? v.ex_rd : 4'($urandom_range(0, 15));
      v.b     = 4'($urandom_range(0, 15));
      v.c     = 4'($urandom_range(0, 15));
      v.ex_re = ($urandom_range(0, 1) == 0);
      v.mre   = ($urandom_range(0, 9) < 4);
      v.mack  = ($urandom_range(0, 9) < 3);
      // Occasionally hold a long unanswered read so dut_b times out.
      if ($urandom_range(0, 99) < 10) begin v.mre = 1'b1; v.mack = 1'b0; end
      apply(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
